iter_div: RTL and testbench
===========================

ITER_DIV -- requirements
Module: iter_div

Interface
REQ-001 The block SHALL declare these ports, in order:
- clk  in  1  clock; all state changes on rising edge.
- rst  in  1  reset; synchronous, active-high.
- signed_div_i  in  1  1 = signed (DIV), 0 = unsigned (DIVU).
- opdata1_i  in  32  dividend.
- opdata2_i  in  32  divisor.
- start_i  in  1  request; the initiator holds it high until ready_o is seen high, then drops it.
- annul_i  in  1  abort an in-flight division.
- result_o  out  64  {remainder[63:32], quotient[31:0]}; registered.
- ready_o  out  1  result valid; registered.
REQ-002 The block SHALL have no parameters; widths are fixed at 32/64.

Function
REQ-003 The block SHALL implement a 4-state FSM: FREE, BYZERO, ON, END.
REQ-004 The iteration counter SHALL be 6 bits, range 0..32.
REQ-005 FREE, start_i=1, annul_i=0, opdata2_i=0: go to BYZERO at that edge.
REQ-006 FREE, start_i=1, annul_i=0, opdata2_i!=0: go to ON at that edge (edge N).
- Latch operand magnitudes: when signed_div_i=1, negative operands are two's-complement negated.
- Latch signed_div_i and both operand sign bits.
- Clear the counter.
REQ-007 FREE with start_i=0, or with annul_i=1, SHALL remain in FREE with outputs unchanged.
REQ-008 Operand inputs SHALL be sampled only at edge N; later changes SHALL be ignored.
REQ-009 ON SHALL perform one restoring shift-subtract step per edge, producing quotient bits MSB first.
- Edges N+1..N+32 perform the 32 steps; the counter increments on each.
REQ-010 ON with counter=32 SHALL, at edge N+33, go to END and load result_o and ready_o=1.
- ready_o is therefore first high in the cycle after edge N+33.
REQ-011 Sign fix-up for signed operation:
- Quotient is negated when the operand signs differ.
- Remainder is negated when the dividend is negative.
- Unsigned operation applies no fix-up.
REQ-012 Signed -2^31 / -1 SHALL yield quotient 0x80000000 and remainder 0 (wrap, no trap).
REQ-013 BYZERO SHALL go to END at the next edge with result_o=0 and ready_o=1.
REQ-014 annul_i=1 in ON or BYZERO SHALL return to FREE at the next edge.
- ready_o stays 0 and result_o stays 0.
- annul_i has priority over step and completion in the same cycle.
REQ-015 END with start_i=1 SHALL hold state, with ready_o=1 and result_o stable.
REQ-016 END with start_i=0 SHALL go to FREE at that edge and clear ready_o and result_o to 0.
REQ-017 A new operation SHALL only be accepted from FREE.
- Back-to-back operations need at least one cycle with start_i=0 between them.
REQ-018 annul_i in END or FREE SHALL have no effect.
REQ-019 ready_o SHALL never be high in FREE, BYZERO or ON.

Reset
REQ-020 rst=1 at any edge, including mid-operation, SHALL force state FREE and counter 0.
- Also clears result_o=0, ready_o=0 and all latched operand/sign registers.
REQ-021 rst SHALL override start_i and annul_i.
REQ-022 The first edge with rst=0 SHALL evaluate normally from FREE.

Verification
REQ-023 Unsigned: 100 / 7 -> ready_o first high after edge N+33; result_o = 0x00000002_0000000E, held while start_i=1.
REQ-024 Signed: -7 / 2 -> result_o = 0xFFFFFFFF_FFFFFFFD; the same operands unsigned -> quotient 0x7FFFFFFC, remainder 0x00000001.
REQ-025 Divide by zero: 5 / 0 -> BYZERO at N, ready_o=1 with result_o=0 after edge N+1; drop start_i -> ready_o=0 next edge.
REQ-026 Overflow: signed 0x80000000 / 0xFFFFFFFF -> result_o = 0x00000000_80000000; 0xFFFFFFFF / 1 unsigned -> quotient 0xFFFFFFFF, remainder 0.
REQ-027 Annul: start 100/7, assert annul_i at edge N+10 -> FREE at N+10, ready_o never rises; a new start at N+12 completes normally after its own N+33.
REQ-028 Reset mid-op: rst at edge N+20 -> all outputs 0, FREE; operand changes at N+5 during an op do not alter the result.

Source files
------------

// File: rtl/iter_div.sv
// Iterative 32/32 divider, restoring shift-subtract, one quotient bit per clock.
// Signed mode divides magnitudes and fixes up signs on completion.
module iter_div (
  input  logic        clk,
  input  logic        rst,
  input  logic        signed_div_i,
  input  logic [31:0] opdata1_i,
  input  logic [31:0] opdata2_i,
  input  logic        start_i,
  input  logic        annul_i,
  output logic [63:0] result_o,
  output logic        ready_o
);

  localparam logic [1:0] FREE   = 2'd0;
  localparam logic [1:0] BYZERO = 2'd1;
  localparam logic [1:0] ON     = 2'd2;
  localparam logic [1:0] END    = 2'd3;

  logic [1:0]  state;
  logic [5:0]  cnt;
  logic [31:0] quo, rem, dvs;
  logic        sgn, neg1, neg2;

  logic [31:0] abs1, abs2, diff, rem_nxt, q_fix, r_fix;
  logic [32:0] shifted;
  logic        ge;

  always_comb begin
    abs1 = (signed_div_i && opdata1_i[31]) ? (~opdata1_i + 32'd1) : opdata1_i;
    abs2 = (signed_div_i && opdata2_i[31]) ? (~opdata2_i + 32'd1) : opdata2_i;
    // quo doubles as the dividend shift register: its MSB feeds the remainder
    shifted = {rem, quo[31]};
    ge      = shifted >= {1'b0, dvs};
    diff    = shifted[31:0] - dvs;
    rem_nxt = ge ? diff : shifted[31:0];
    q_fix   = (sgn && (neg1 ^ neg2)) ? (~quo + 32'd1) : quo;
    r_fix   = (sgn && neg1) ? (~rem + 32'd1) : rem;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= FREE;
      cnt      <= 6'd0;
      quo      <= 32'd0;
      rem      <= 32'd0;
      dvs      <= 32'd0;
      sgn      <= 1'b0;
      neg1     <= 1'b0;
      neg2     <= 1'b0;
      result_o <= 64'd0;
      ready_o  <= 1'b0;
    end else begin
      case (state)
        FREE: begin
          if (start_i && !annul_i) begin
            if (opdata2_i == 32'd0) begin
              state <= BYZERO;
            end else begin
              state <= ON;
              quo   <= abs1;
              dvs   <= abs2;
              rem   <= 32'd0;
              cnt   <= 6'd0;
              sgn   <= signed_div_i;
              neg1  <= opdata1_i[31];
              neg2  <= opdata2_i[31];
            end
          end
        end
        BYZERO: begin
          if (annul_i) begin
            state <= FREE;
          end else begin
            state    <= END;
            result_o <= 64'd0;
            ready_o  <= 1'b1;
          end
        end
        ON: begin
          if (annul_i) begin
            state <= FREE;
          end else if (cnt == 6'd32) begin
            state    <= END;
            result_o <= {r_fix, q_fix};
            ready_o  <= 1'b1;
          end else begin
            rem <= rem_nxt;
            quo <= {quo[30:0], ge};
            cnt <= cnt + 6'd1;
          end
        end
        default: begin
          // END: hold the result until the initiator drops its request
          if (!start_i) begin
            state    <= FREE;
            result_o <= 64'd0;
            ready_o  <= 1'b0;
          end
        end
      endcase
    end
  end

endmodule

// File: tb/tb_iter_div.sv
// Random and directed checks of iter_div against an arithmetic reference model.
module tb_iter_div;
  logic        clk = 1'b0;
  logic        rst;
  logic        signed_div;
  logic [31:0] opdata1, opdata2;
  logic        start, annul;
  logic [63:0] result;
  logic        ready;

  int checks = 0;
  int errors = 0;

  iter_div dut (
    .clk(clk), .rst(rst), .signed_div_i(signed_div),
    .opdata1_i(opdata1), .opdata2_i(opdata2),
    .start_i(start), .annul_i(annul),
    .result_o(result), .ready_o(ready)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %h expected %h", tag, got, exp);
    end
  endtask

  function automatic logic [63:0] model(input logic [31:0] a, input logic [31:0] b, input logic s);
    int sa, sb, q, r;
    if (b == 32'd0) return 64'd0;
    if (!s) return {a % b, a / b};
    if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return {32'd0, 32'h8000_0000};
    sa = a; sb = b;
    q = sa / sb;
    r = sa % sb;
    return {r, q};
  endfunction

  task automatic tick();
    @(posedge clk); #1;
  endtask

  // Issue one request and follow it to completion; operands are scrambled after acceptance.
  task automatic do_op(input logic [31:0] a, input logic [31:0] b, input logic s);
    logic [63:0] exp;
    int lat;
    exp = model(a, b, s);
    @(negedge clk);
    signed_div = s; opdata1 = a; opdata2 = b; start = 1'b1;
    tick();
    lat = 0;
    while (!ready && lat < 40) begin
      @(negedge clk);
      opdata1 = $urandom; opdata2 = $urandom; signed_div = 1'($urandom);
      tick();
      lat++;
    end
    chk("latency", 64'(lat), (b == 32'd0) ? 64'd1 : 64'd33);
    chk("result", result, exp);
    @(negedge clk); annul = 1'b1;
    tick();
    chk("hold_ready", 64'(ready), 64'd1);
    chk("hold_result", result, exp);
    @(negedge clk); annul = 1'b0; start = 1'b0;
    tick();
    chk("drop_ready", 64'(ready), 64'd0);
    chk("drop_result", result, 64'd0);
  endtask

  initial begin
    logic [31:0] a, b;
    logic s;
    rst = 1'b1; start = 1'b0; annul = 1'b0; signed_div = 1'b0;
    opdata1 = 32'd0; opdata2 = 32'd0;
    tick(); tick();
    chk("reset_ready", 64'(ready), 64'd0);
    chk("reset_result", result, 64'd0);
    @(negedge clk); rst = 1'b0;

    do_op(32'd100, 32'd7, 1'b0);
    do_op(-32'sd7, 32'd2, 1'b1);
    do_op(-32'sd7, 32'd2, 1'b0);
    do_op(32'd5, 32'd0, 1'b1);
    do_op(32'h8000_0000, 32'hFFFF_FFFF, 1'b1);
    do_op(32'hFFFF_FFFF, 32'd1, 1'b0);
    do_op(32'd0, 32'd5, 1'b1);
    do_op(32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0);
    do_op(32'd7, -32'sd3, 1'b1);

    // annul in ON at edge N+10, restart at N+12
    @(negedge clk); signed_div = 1'b0; opdata1 = 32'd100; opdata2 = 32'd7; start = 1'b1;
    tick();
    for (int i = 1; i <= 9; i++) tick();
    @(negedge clk); annul = 1'b1; start = 1'b0;
    tick();
    chk("annul_ready", 64'(ready), 64'd0);
    @(negedge clk); annul = 1'b0;
    tick();
    chk("annul_idle_ready", 64'(ready), 64'd0);
    chk("annul_idle_result", result, 64'd0);
    do_op(32'd1000, 32'd9, 1'b0);

    // annul in BYZERO
    @(negedge clk); opdata1 = 32'd5; opdata2 = 32'd0; start = 1'b1;
    tick();
    @(negedge clk); annul = 1'b1; start = 1'b0;
    tick();
    chk("annul_byzero_ready", 64'(ready), 64'd0);
    @(negedge clk); annul = 1'b0;
    tick(); tick();
    chk("annul_byzero_idle", 64'(ready), 64'd0);

    // reset at edge N+20
    @(negedge clk); signed_div = 1'b1; opdata1 = -32'sd1000; opdata2 = 32'd3; start = 1'b1;
    tick();
    for (int i = 1; i <= 19; i++) tick();
    @(negedge clk); rst = 1'b1;
    tick();
    chk("midrst_ready", 64'(ready), 64'd0);
    chk("midrst_result", result, 64'd0);
    @(negedge clk); rst = 1'b0; start = 1'b0;
    tick(); tick();
    chk("midrst_idle", 64'(ready), 64'd0);
    do_op(-32'sd1000, 32'd3, 1'b1);

    for (int i = 0; i < 30; i++) begin
      a = $urandom;
      b = ($urandom_range(0, 7) == 0) ? 32'd0 : $urandom >> $urandom_range(0, 31);
      s = 1'($urandom);
      do_op(a, b, s);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL timeout got 0 expected 1");
    $fatal(1);
  end
endmodule
